// File: rtl/trng_harvest_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator entropy harvester.
package trng_harvest_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FAIL    = 3'd4
    } trng_state_e;

    // New samples enter at the LSB, so the first sample of a byte ends up as the MSB.
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] sr, input logic b);
        return {sr[BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/trng_harvest_ctrl_if.sv
// Byte stream handshake between the harvester and its consumer.
interface trng_harvest_ctrl_if;
    logic [trng_harvest_ctrl_pkg::BYTE_W-1:0] data_out;
    logic                                     data_valid;
    logic                                     data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/trng_harvest_ctrl_rct.sv
// Repetition-count health test: flags a run of RCT_CUTOFF identical samples.
module trng_rct #(
    parameter int unsigned RCT_CUTOFF = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    input  logic bit_i,
    input  logic restart_i,
    output logic fail_o
);
    logic [7:0] run_q, run_d;
    logic       prev_q, prev_d;
    logic       first_q, first_d;

    // Run-length tracking; the run saturates so it can never wrap back below the cutoff.
    always_comb begin
        run_d   = run_q;
        prev_d  = prev_q;
        first_d = first_q;
        if (restart_i) begin
            run_d   = 8'd0;
            first_d = 1'b1;
        end else if (strobe_i) begin
            prev_d  = bit_i;
            first_d = 1'b0;
            if (first_q || (bit_i != prev_q)) begin
                run_d = 8'd1;
            end else if (run_q != 8'hFF) begin
                run_d = run_q + 8'd1;
            end else begin
                run_d = run_q;
            end
        end else begin
            run_d = run_q;
        end
    end

    assign fail_o = strobe_i && !restart_i && (run_d == 8'(RCT_CUTOFF));

    // Run-count state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 8'd0;
            prev_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            run_q   <= run_d;
            prev_q  <= prev_d;
            first_q <= first_d;
        end
    end
endmodule

// File: rtl/trng_harvest_ctrl.sv
// Entropy harvest sequencer: warm-up, decimated sampling, byte packing,
// valid/ready presentation and a sticky repetition-count failure state.
module trng_harvest_ctrl
    import trng_harvest_ctrl_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 256,
    parameter int unsigned RCT_CUTOFF    = 16,
    parameter int unsigned DIV_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic                     clr_fail,
    input  logic [DIV_W-1:0]         sample_div,
    input  logic                     raw_bit,
    output logic                     osc_en,
    output logic                     busy,
    output logic                     health_fail,
    trng_harvest_ctrl_if.master      stream
);
    localparam int unsigned WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    trng_state_e       state_q, state_d;
    logic              sync1_q, sync2_q;
    logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d, div_cnt_q, div_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] sr_q, sr_d, data_q, data_d;
    logic              osc_en_q, valid_q, busy_q, fail_q;
    logic              strobe_s, rct_restart_s, rct_fail_s;

    assign strobe_s      = ena && (state_q == ST_SAMPLE) && (div_cnt_q == div_q);
    assign rct_restart_s = (state_q == ST_WARMUP);

    trng_rct #(.RCT_CUTOFF(RCT_CUTOFF)) u_rct (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe_i  (strobe_s),
        .bit_i     (sync2_q),
        .restart_i (rct_restart_s),
        .fail_o    (rct_fail_s)
    );

    // Session sequencing, decimation and byte assembly.
    always_comb begin
        state_d   = state_q;
        wu_cnt_d  = wu_cnt_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start && ena) begin
                    state_d  = ST_WARMUP;
                    wu_cnt_d = WU_W'(WARMUP_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (wu_cnt_q == '0) begin
                    state_d   = ST_SAMPLE;
                    div_d     = sample_div;
                    div_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                end else begin
                    wu_cnt_d = wu_cnt_q - WU_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (strobe_s) begin
                    div_cnt_d = '0;
                    sr_d      = shift_in(sr_q, sync2_q);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // A health failure on the closing strobe discards the byte.
                    if (rct_fail_s) begin
                        state_d = ST_FAIL;
                    end else if (bit_cnt_q == 3'd7) begin
                        data_d  = shift_in(sr_q, sync2_q);
                        state_d = ST_PRESENT;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_PRESENT: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (stream.data_ready) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_FAIL: begin
                if (clr_fail) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            wu_cnt_q  <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            sr_q      <= '0;
            data_q    <= '0;
            osc_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= raw_bit;
            sync2_q   <= sync1_q;
            wu_cnt_q  <= wu_cnt_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            osc_en_q  <= (state_d == ST_WARMUP) || (state_d == ST_SAMPLE) || (state_d == ST_PRESENT);
            valid_q   <= (state_d == ST_PRESENT);
            busy_q    <= (state_d != ST_IDLE);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign osc_en            = osc_en_q;
    assign busy              = busy_q;
    assign health_fail       = fail_q;
    assign stream.data_out   = data_q;
    assign stream.data_valid = valid_q;
endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// Directed bench for trng_harvest_ctrl with hand-computed byte and timing expectations.
module tb_trng_harvest_ctrl;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       clr_fail;
    logic [7:0] sample_div;
    logic       raw_bit;
    logic       osc_en;
    logic       busy;
    logic       health_fail;
    int         vec_cnt;
    int         miscmp_cnt;

    trng_harvest_ctrl_if u_if ();

    trng_harvest_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .clr_fail    (clr_fail),
        .sample_div  (sample_div),
        .raw_bit     (raw_bit),
        .osc_en      (osc_en),
        .busy        (busy),
        .health_fail (health_fail),
        .stream      (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts a session (edge 0) and drives raw_bit so that sample j of the byte
    // (MSB first) is the value captured two edges before strobe j.
    task automatic session(input logic [7:0] d, input logic [7:0] pat, input int n_edges);
        int m;
        int j;
        sample_div = d;
        raw_bit    = pat[7];
        start      = 1'b1;
        cyc();
        start = 1'b0;
        chk_eq("osc_en_after_start", {31'd0, osc_en}, 32'd1);
        chk_eq("busy_after_start", {31'd0, busy}, 32'd1);
        for (int n = 1; n <= n_edges; n++) begin
            m = n + 2 - 256;
            if (m < 1) j = 1;
            else j = (m + int'(d)) / (int'(d) + 1);
            if (j > 8) j = 8;
            raw_bit = pat[8-j];
            cyc();
        end
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        start      = 1'b0;
        clr_fail   = 1'b0;
        sample_div = 8'd0;
        raw_bit    = 1'b0;
        u_if.data_ready = 1'b0;
        repeat (3) cyc();
        chk_eq("rst_osc_en", {31'd0, osc_en}, 32'd0);
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_health_fail", {31'd0, health_fail}, 32'd0);
        chk_eq("rst_data_valid", {31'd0, u_if.data_valid}, 32'd0);
        chk_eq("rst_data_out", {24'd0, u_if.data_out}, 32'd0);
        rst_n = 1'b1;
        cyc();
        ena = 1'b1;

        // div=0: strobes on edges 257..264, byte presented after edge 264.
        session(8'd0, 8'h5A, 263);
        chk_eq("div0_valid_early", {31'd0, u_if.data_valid}, 32'd0);
        cyc();
        chk_eq("div0_valid", {31'd0, u_if.data_valid}, 32'd1);
        chk_eq("div0_byte", {24'd0, u_if.data_out}, 32'h5A);

        // Asynchronous reset while presenting, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_data_valid", {31'd0, u_if.data_valid}, 32'd0);
        chk_eq("arst_osc_en", {31'd0, osc_en}, 32'd0);
        chk_eq("arst_busy", {31'd0, busy}, 32'd0);
        chk_eq("arst_health_fail", {31'd0, health_fail}, 32'd0);
        chk_eq("arst_data_out", {24'd0, u_if.data_out}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // div=3: strobes every 4 edges from 260, byte after edge 288.
        session(8'd3, 8'hB2, 287);
        chk_eq("div3_valid_early", {31'd0, u_if.data_valid}, 32'd0);
        cyc();
        chk_eq("div3_valid", {31'd0, u_if.data_valid}, 32'd1);
        chk_eq("div3_byte", {24'd0, u_if.data_out}, 32'hB2);

        // Back-pressure: byte must hold while raw_bit keeps moving.
        for (int i = 0; i < 50; i++) begin
            raw_bit = ~raw_bit;
            cyc();
        end
        chk_eq("hold_byte", {24'd0, u_if.data_out}, 32'hB2);
        chk_eq("hold_valid", {31'd0, u_if.data_valid}, 32'd1);
        u_if.data_ready = 1'b1;
        cyc();
        u_if.data_ready = 1'b0;
        chk_eq("accept_valid_low", {31'd0, u_if.data_valid}, 32'd0);
        chk_eq("accept_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 31; i++) begin
            raw_bit = ~raw_bit;
            cyc();
        end
        chk_eq("resume_valid_early", {31'd0, u_if.data_valid}, 32'd0);
        cyc();
        chk_eq("resume_valid", {31'd0, u_if.data_valid}, 32'd1);
        ena = 1'b0;
        cyc();
        chk_eq("ena_abort_busy", {31'd0, busy}, 32'd0);
        chk_eq("ena_abort_valid", {31'd0, u_if.data_valid}, 32'd0);
        chk_eq("ena_abort_osc", {31'd0, osc_en}, 32'd0);
        ena = 1'b1;
        cyc();

        // Constant ones: first byte FF (run 8), run reaches 16 on the next byte's 8th strobe.
        session(8'd0, 8'hFF, 263);
        cyc();
        chk_eq("ones_valid", {31'd0, u_if.data_valid}, 32'd1);
        chk_eq("ones_byte", {24'd0, u_if.data_out}, 32'hFF);
        u_if.data_ready = 1'b1;
        cyc();
        u_if.data_ready = 1'b0;
        chk_eq("ones_accept", {31'd0, u_if.data_valid}, 32'd0);
        repeat (7) cyc();
        chk_eq("ones_hf_early", {31'd0, health_fail}, 32'd0);
        cyc();
        chk_eq("ones_hf", {31'd0, health_fail}, 32'd1);
        chk_eq("ones_fail_osc", {31'd0, osc_en}, 32'd0);
        chk_eq("ones_fail_valid", {31'd0, u_if.data_valid}, 32'd0);
        chk_eq("ones_fail_busy", {31'd0, busy}, 32'd1);
        start = 1'b1;
        ena   = 1'b0;
        cyc();
        start = 1'b0;
        repeat (20) cyc();
        chk_eq("fail_sticky", {31'd0, health_fail}, 32'd1);
        chk_eq("fail_no_valid", {31'd0, u_if.data_valid}, 32'd0);
        clr_fail = 1'b1;
        cyc();
        clr_fail = 1'b0;
        chk_eq("clr_busy", {31'd0, busy}, 32'd0);
        chk_eq("clr_hf", {31'd0, health_fail}, 32'd0);
        ena = 1'b1;
        cyc();

        // Abort after 5 strobes (edges 257..261), then a fresh session.
        raw_bit    = 1'b1;
        sample_div = 8'd0;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        repeat (261) cyc();
        chk_eq("abort_no_valid", {31'd0, u_if.data_valid}, 32'd0);
        ena = 1'b0;
        cyc();
        chk_eq("abort_busy", {31'd0, busy}, 32'd0);
        chk_eq("abort_osc", {31'd0, osc_en}, 32'd0);
        ena = 1'b1;
        session(8'd0, 8'hC3, 263);
        chk_eq("rerun_valid_early", {31'd0, u_if.data_valid}, 32'd0);
        cyc();
        chk_eq("rerun_valid", {31'd0, u_if.data_valid}, 32'd1);
        chk_eq("rerun_byte", {24'd0, u_if.data_out}, 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule
